dmem_ctrl: RTL and testbench

Data-memory access controller between two requesters and the single-port word-addressed data memory (combinational read, synchronous write).
- Requesters: pipeline MEM stage (core_*) and program/debug loader (dma_*).
- Arbitrates between them and performs RISC-V sub-word loads (LB/LH/LW/LBU/LHU) with byte-lane extraction and sign/zero extension.
- Performs SB/SH as read-modify-write; flags misaligned and out-of-range accesses.

---
 rtl/dmem_ctrl_pkg.sv | 31 +++
 rtl/dmem_lane_unit.sv | 49 ++++
 rtl/dmem_ctrl.sv | 168 ++++++++++++++++
 tb/tb_dmem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared funct3 codes, FSM/requester types and access checking for dmem_ctrl
package dmem_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;
    typedef enum logic {CORE, DMA} req_id_t;

    // Misalignment, unsupported funct3 (stores only accept SB/SH/SW) or word index beyond depth.
    function automatic logic access_err(input logic we, input logic [31:0] addr,
                                        input logic [2:0] funct3, input int unsigned depth);
        logic bad;
        case (funct3)
            F3_LB:   bad = 1'b0;
            F3_LH:   bad = addr[0];
            F3_LW:   bad = addr[1] | addr[0];
            F3_LBU:  bad = we;
            F3_LHU:  bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        return bad | ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - sub-word load extraction/extension and SB/SH lane merge
module dmem_lane_unit
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];

        load_data = 32'h0;
        case (funct3)
            F3_LB:   load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   load_data = {{16{half_lane[15]}}, half_lane};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'h0, byte_lane};
            F3_LHU:  load_data = {16'h0, half_lane};
            default: load_data = 32'h0;
        endcase

        merge_data = word;
        if (funct3 == F3_SB) begin
            case (addr_lo)
                2'd0:    merge_data[7:0]   = wdata[7:0];
                2'd1:    merge_data[15:8]  = wdata[7:0];
                2'd2:    merge_data[23:16] = wdata[7:0];
                default: merge_data[31:24] = wdata[7:0];
            endcase
        end else if (funct3 == F3_SH) begin
            if (addr_lo[1]) merge_data[31:16] = wdata;
            else            merge_data[15:0]  = wdata;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - two-port data-memory controller; DMEM_CTRL_RR_EN selects round-robin over fixed core priority
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_funct3,
    output logic        core_ack,
    output logic [31:0] core_rdata,
    output logic        core_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [2:0]  dma_funct3,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    req_id_t     owner;
    logic        we_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;
    logic [2:0]  funct3_q;
    logic        err_q;
    logic        mem_we_q;

    logic        pick_dma;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_funct3;
    logic        sel_err;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic [31:0] resp_rdata;
    logic        needs_merge;
    logic        finish;

`ifdef DMEM_CTRL_RR_EN
    req_id_t rr_ptr;
    always_comb pick_dma = dma_req & (~core_req | (rr_ptr == DMA));
`else
    always_comb pick_dma = dma_req & ~core_req;
`endif

    always_comb begin
        sel_we     = pick_dma ? dma_we     : core_we;
        sel_addr   = pick_dma ? dma_addr   : core_addr;
        sel_wdata  = pick_dma ? dma_wdata  : core_wdata;
        sel_funct3 = pick_dma ? dma_funct3 : core_funct3;
        sel_err    = access_err(sel_we, sel_addr, sel_funct3, DEPTH);
    end

    dmem_lane_unit u_lane (
        .word       (mem_rdata),
        .addr_lo    (addr_lo_q),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        needs_merge = ~err_q & we_q & (funct3_q != F3_SW);
        finish      = ((state == ACCESS) & ~needs_merge) | (state == MERGE);
        resp_rdata  = (err_q | we_q) ? 32'h0 : load_data;
    end

    // Gating with rst_n keeps a reset that lands on a write cycle from reaching the memory.
    assign mem_we = mem_we_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= CORE;
            we_q       <= 1'b0;
            addr_lo_q  <= 2'b00;
            wdata_q    <= 16'h0;
            funct3_q   <= 3'b000;
            err_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            core_ack   <= 1'b0;
            core_rdata <= 32'h0;
            core_err   <= 1'b0;
            dma_ack    <= 1'b0;
            dma_rdata  <= 32'h0;
            dma_err    <= 1'b0;
`ifdef DMEM_CTRL_RR_EN
            rr_ptr     <= CORE;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (core_req | dma_req) begin
                        owner     <= pick_dma ? DMA : CORE;
                        we_q      <= sel_we;
                        addr_lo_q <= sel_addr[1:0];
                        wdata_q   <= sel_wdata[15:0];
                        funct3_q  <= sel_funct3;
                        err_q     <= sel_err;
                        if (!sel_err) begin
                            mem_addr <= {2'b00, sel_addr[31:2]};
                            if (sel_we && sel_funct3 == F3_SW) begin
                                mem_we_q  <= 1'b1;
                                mem_wdata <= sel_wdata;
                            end
                        end
`ifdef DMEM_CTRL_RR_EN
                        rr_ptr <= pick_dma ? CORE : DMA;
`endif
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (needs_merge) begin
                        mem_wdata <= merge_data;
                        mem_we_q  <= 1'b1;
                        state     <= MERGE;
                    end else begin
                        mem_we_q <= 1'b0;
                        state    <= RESP;
                    end
                end
                MERGE: begin
                    mem_we_q <= 1'b0;
                    state    <= RESP;
                end
                default: begin
                    core_ack   <= 1'b0;
                    core_rdata <= 32'h0;
                    core_err   <= 1'b0;
                    dma_ack    <= 1'b0;
                    dma_rdata  <= 32'h0;
                    dma_err    <= 1'b0;
                    state      <= IDLE;
                end
            endcase

            if (finish) begin
                if (owner == CORE) begin
                    core_ack   <= 1'b1;
                    core_rdata <= resp_rdata;
                    core_err   <= err_q;
                end else begin
                    dma_ack    <= 1'b1;
                    dma_rdata  <= resp_rdata;
                    dma_err    <= err_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl and dmem_lane_unit
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, core_ack, core_err;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [2:0]  core_funct3;
    logic        dma_req, dma_we, dma_ack, dma_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [2:0]  dma_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_funct3(core_funct3), .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_funct3(dma_funct3), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    logic [31:0] l_word, l_load, l_merge;
    logic [1:0]  l_addr;
    logic [2:0]  l_f3;
    logic [15:0] l_wdata;

    dmem_lane_unit u_lane (
        .word(l_word), .addr_lo(l_addr), .funct3(l_f3), .wdata(l_wdata),
        .load_data(l_load), .merge_data(l_merge)
    );

    logic [31:0] mem [DEPTH];
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = 10'd0;
    logic [31:0] ld_data = 32'h0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[9:0]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state: the first 16 words of memory, updated by spec rules.
    logic [31:0] ref_mem [16];

    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] f3, output logic [31:0] rd, output logic er,
                                  output int lat, output int nwe);
        int unsigned widx = addr >> 2;
        int          off  = int'(addr & 32'd3);
        logic [31:0] w, b, h;
        rd = 0; lat = 2; nwe = 0;
        er = (widx >= DEPTH);
        if (!we) er = er | (f3 == 3) | (f3 == 6) | (f3 == 7);
        else     er = er | (f3 > 2);
        if ((f3 == 1 || f3 == 5) && (off % 2) != 0) er = 1;
        if (f3 == 2 && off != 0) er = 1;
        if (er) return;
        w = ref_mem[widx % 16];
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (!we) begin
            case (f3)
                0: rd = (b < 128) ? b : b + 32'hFFFFFF00;
                1: rd = (h < 32768) ? h : h + 32'hFFFF0000;
                2: rd = w;
                4: rd = b;
                default: rd = h;
            endcase
        end else begin
            nwe = 1;
            case (f3)
                0: begin ref_mem[widx % 16] = (w & ~(32'hFF << (8 * off))) | ((wdata & 32'hFF) << (8 * off)); lat = 3; end
                1: begin ref_mem[widx % 16] = (w & ~(32'hFFFF << (16 * (off / 2)))) | ((wdata & 32'hFFFF) << (16 * (off / 2))); lat = 3; end
                default: ref_mem[widx % 16] = wdata;
            endcase
        end
    endfunction

    task automatic xact(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nwe, output int oth, output logic [31:0] waddr);
        @(negedge clk);
        if (port) begin
            dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_funct3 = f3;
        end else begin
            core_req = 1; core_we = we; core_addr = addr; core_wdata = wdata; core_funct3 = f3;
        end
        rd = 0; er = 0; lat = 0; nwe = 0; oth = 0; waddr = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_we) begin nwe++; waddr = mem_addr; end
            if (port ? core_ack : dma_ack) oth++;
            if (port ? dma_ack : core_ack) begin
                rd  = port ? dma_rdata : core_rdata;
                er  = port ? dma_err : core_err;
                lat = k;
                break;
            end
        end
        core_req = 0;
        dma_req  = 0;
    endtask

    typedef struct {
        logic port; logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] f3;
        logic [31:0] exp_rd; logic exp_er; int exp_lat; int exp_nwe;
    } vec_t;

    function automatic vec_t mk(input logic port, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                input logic [31:0] exp_rd, input logic exp_er,
                                input int exp_lat, input int exp_nwe);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
        v.exp_rd = exp_rd; v.exp_er = exp_er; v.exp_lat = exp_lat; v.exp_nwe = exp_nwe;
        return v;
    endfunction

    typedef struct {
        logic [31:0] word; logic [1:0] addr; logic [2:0] f3; logic [15:0] wdata;
        logic [31:0] exp_load; logic [31:0] exp_merge;
    } lane_vec_t;

    initial begin
        vec_t        tbl[$];
        lane_vec_t   ltbl[$];
        lane_vec_t   lv;
        logic [31:0] rd, exp_rd, waddr, bad;
        logic        er, exp_er;
        int          lat, nwe, oth, exp_lat, exp_nwe, acks, ack_at;
        int          owners[$];

        rst_n = 0;
        core_req = 1; core_we = 0; core_addr = 0; core_wdata = 0; core_funct3 = F3_LW;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_funct3 = 0;
        l_word = 0; l_addr = 0; l_f3 = 0; l_wdata = 0;

        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bad = bad | {31'h0, core_ack | dma_ack | mem_we | core_err | dma_err}
                      | core_rdata | dma_rdata | mem_addr | mem_wdata;
        end
        check("reset_outputs", bad, 32'h0);
        rst_n = 1;
        ack_at = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (core_ack) begin ack_at = k; break; end
        end
        core_req = 0;
        check("reset_release_latency", ack_at, 2);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_en = 1; ld_idx = 10'(i); ld_data = $urandom;
            ref_mem[i] = ld_data;
        end
        @(negedge clk);
        ld_en = 0;

        ltbl.push_back('{32'h11223344, 2'd3, 3'b000, 16'h00EE, 32'h00000011, 32'hEE223344});
        ltbl.push_back('{32'h80FF7F01, 2'd1, 3'b000, 16'h1200, 32'h0000007F, 32'h80FF0001});
        ltbl.push_back('{32'h80FF7F01, 2'd2, 3'b100, 16'h1234, 32'h000000FF, 32'h80FF7F01});
        ltbl.push_back('{32'h80FF7F01, 2'd2, 3'b001, 16'h1234, 32'hFFFF80FF, 32'h12347F01});
        ltbl.push_back('{32'h80FF7F01, 2'd0, 3'b101, 16'h1234, 32'h00007F01, 32'h80FF7F01});
        ltbl.push_back('{32'h80FF7F01, 2'd0, 3'b010, 16'h1234, 32'h80FF7F01, 32'h80FF7F01});
        ltbl.push_back('{32'h80FF7F01, 2'd1, 3'b111, 16'h1234, 32'h00000000, 32'h80FF7F01});
        foreach (ltbl[i]) begin
            lv = ltbl[i];
            l_word = lv.word; l_addr = lv.addr; l_f3 = lv.f3; l_wdata = lv.wdata;
            #1;
            check($sformatf("lane_load[%0d]", i), l_load, lv.exp_load);
            check($sformatf("lane_merge[%0d]", i), l_merge, lv.exp_merge);
        end

        tbl.push_back(mk(0, 1, 32'h100, 32'hDEADBEEF, F3_SW,  32'h0,        0, 2, 1));
        tbl.push_back(mk(0, 0, 32'h100, 32'h0,        F3_LW,  32'hDEADBEEF, 0, 2, 0));
        tbl.push_back(mk(0, 1, 32'h100, 32'h11223344, F3_SW,  32'h0,        0, 2, 1));
        tbl.push_back(mk(0, 1, 32'h101, 32'hFFFFFFAB, F3_SB,  32'h0,        0, 3, 1));
        tbl.push_back(mk(0, 0, 32'h100, 32'h0,        F3_LW,  32'h1122AB44, 0, 2, 0));
        tbl.push_back(mk(0, 0, 32'h101, 32'h0,        F3_LB,  32'hFFFFFFAB, 0, 2, 0));
        tbl.push_back(mk(0, 0, 32'h101, 32'h0,        F3_LBU, 32'h000000AB, 0, 2, 0));
        tbl.push_back(mk(0, 0, 32'h102, 32'h0,        F3_LH,  32'h00001122, 0, 2, 0));
        tbl.push_back(mk(0, 0, 32'h100, 32'h0,        F3_LH,  32'hFFFFAB44, 0, 2, 0));
        tbl.push_back(mk(0, 0, 32'h102, 32'h0,        F3_LW,  32'h0,        1, 2, 0));
        tbl.push_back(mk(0, 1, 32'h103, 32'h1234,     F3_SH,  32'h0,        1, 2, 0));
        tbl.push_back(mk(0, 0, 32'(4 * DEPTH), 32'h0, F3_LW,  32'h0,        1, 2, 0));
        tbl.push_back(mk(0, 0, 32'h100, 32'h0,        3'b011, 32'h0,        1, 2, 0));
        tbl.push_back(mk(0, 1, 32'h100, 32'h0,        3'b011, 32'h0,        1, 2, 0));
        tbl.push_back(mk(0, 1, 32'h102, 32'h99995566, F3_SH,  32'h0,        0, 3, 1));
        tbl.push_back(mk(1, 0, 32'h102, 32'h0,        F3_LHU, 32'h00005566, 0, 2, 0));
        tbl.push_back(mk(1, 0, 32'h100, 32'h0,        F3_LW,  32'h5566AB44, 0, 2, 0));
        foreach (tbl[i]) begin
            xact(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, er, lat, nwe, oth, waddr);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_er});
            check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            check($sformatf("vec%0d_mem_we_cycles", i), nwe, tbl[i].exp_nwe);
            check($sformatf("vec%0d_other_ack", i), oth, 0);
            if (tbl[i].exp_nwe > 0) check($sformatf("vec%0d_mem_addr", i), waddr, tbl[i].addr >> 2);
        end

        for (int i = 0; i < 80; i++) begin
            logic [31:0] widx, addr, wdata;
            logic [2:0]  f3;
            logic        we, port;
            widx  = ($urandom_range(0, 9) == 0) ? 32'(DEPTH) + $urandom_range(0, 100) : $urandom_range(0, 15);
            addr  = widx * 4 + $urandom_range(0, 3);
            wdata = $urandom;
            f3    = 3'($urandom_range(0, 7));
            we    = 1'($urandom_range(0, 1));
            port  = 1'($urandom_range(0, 1));
            model(we, addr, wdata, f3, exp_rd, exp_er, exp_lat, exp_nwe);
            xact(port, we, addr, wdata, f3, rd, er, lat, nwe, oth, waddr);
            check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            check($sformatf("rnd%0d_err", i), {31'h0, er}, {31'h0, exp_er});
            check($sformatf("rnd%0d_latency", i), lat, exp_lat);
            check($sformatf("rnd%0d_mem_we_cycles", i), nwe, exp_nwe);
        end
        for (int i = 0; i < 16; i++) check($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

        // A dma grant first leaves the round-robin pointer on core.
        xact(1, 0, 32'h100, 32'h0, F3_LW, rd, er, lat, nwe, oth, waddr);
        check("pre_contention_rdata", rd, 32'h5566AB44);
        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 32'h100; core_funct3 = F3_LW;
        dma_req  = 1; dma_we  = 0; dma_addr  = 32'h104; dma_funct3  = F3_LW;
        for (int k = 0; k < 40 && owners.size() < 4; k++) begin
            @(negedge clk);
            if (core_ack) owners.push_back(0);
            if (dma_ack)  owners.push_back(1);
        end
        core_req = 0; dma_req = 0;
        check("contention_ack_count", owners.size(), 4);
        for (int i = 0; i < owners.size() && i < 4; i++) begin
`ifdef DMEM_CTRL_RR_EN
            check($sformatf("contention_owner[%0d]", i), owners[i], i % 2);
`else
            check($sformatf("contention_owner[%0d]", i), owners[i], 0);
`endif
        end

        xact(0, 1, 32'h200, 32'hCAFEF00D, F3_SW, rd, er, lat, nwe, oth, waddr);
        check("abort_setup_latency", lat, 2);
        @(negedge clk);
        core_req = 1; core_we = 1; core_addr = 32'h200; core_wdata = 32'h77; core_funct3 = F3_SB;
        @(negedge clk);
        @(negedge clk);
        check("abort_merge_we", {31'h0, mem_we}, 32'h1);
        rst_n = 0;
        core_req = 0;
        #1;
        check("abort_reset_gates_we", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        check("abort_no_ack", {31'h0, core_ack}, 32'h0);
        rst_n = 1;
        xact(0, 0, 32'h200, 32'h0, F3_LW, rd, er, lat, nwe, oth, waddr);
        check("abort_word_unchanged", rd, 32'hCAFEF00D);

        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 32'h200; core_funct3 = F3_LW;
        @(negedge clk);
        core_req = 0;
        acks = 0; ack_at = 0;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            if (core_ack) begin acks++; ack_at = k; end
        end
        check("drop_req_ack_count", acks, 1);
        check("drop_req_ack_cycle", ack_at, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
